// File: rtl/tile_text_writer.sv
// Text-cursor writer for the tile map: turns a char/attr byte stream into {attr,char}
// RAM words, yielding the RAM port to the renderer whenever ram_busy is high.
module tile_text_writer #(
  parameter int          COLS       = 32,
  parameter int          ROWS       = 30,
  parameter logic [15:0] BASE       = 16'h0000,
  parameter logic [15:0] CLEAR_WORD = 16'h0020
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [7:0]  i_in_char,
  input  logic [7:0]  i_in_attr,
  input  logic        i_ram_busy,
  output logic [15:0] o_ram_addr,
  output logic [15:0] o_ram_write,
  output logic        o_ram_writeenable,
  output logic [7:0]  o_cur_col,
  output logic [7:0]  o_cur_row
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  localparam logic [7:0]  LAST_COL  = 8'(COLS - 1);
  localparam logic [7:0]  LAST_ROW  = 8'(ROWS - 1);
  localparam logic [15:0] LAST_CELL = 16'(COLS * ROWS - 1);

  state_t      r_state, w_stateNext;
  logic [7:0]  r_col, r_row, w_colNext, w_rowNext, w_rowInc;
  logic [15:0] r_addr, r_data, r_clrCnt;
  logic [15:0] w_addrNext, w_dataNext, w_clrCntNext, w_cellAddr;
  logic        w_accept;

  assign w_accept   = i_in_valid && (r_state == IDLE);
  assign w_rowInc   = (r_row == LAST_ROW) ? 8'd0 : r_row + 8'd1;
  // Computed wide then truncated so large BASE values simply wrap the 16-bit space.
  assign w_cellAddr = 16'(32'(BASE) + 32'(r_row) * 32'(COLS) + 32'(r_col));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_col    <= 8'd0;
      r_row    <= 8'd0;
      r_addr   <= BASE;
      r_data   <= 16'd0;
      r_clrCnt <= 16'd0;
    end else begin
      r_state  <= w_stateNext;
      r_col    <= w_colNext;
      r_row    <= w_rowNext;
      r_addr   <= w_addrNext;
      r_data   <= w_dataNext;
      r_clrCnt <= w_clrCntNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_colNext    = r_col;
    w_rowNext    = r_row;
    w_addrNext   = r_addr;
    w_dataNext   = r_data;
    w_clrCntNext = r_clrCnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (i_in_char)
            8'h0D: w_colNext = 8'd0;
            8'h0A: begin
              w_colNext = 8'd0;
              w_rowNext = w_rowInc;
            end
            8'h08: begin
              if (r_col != 8'd0) w_colNext = r_col - 8'd1;
            end
            8'h0C: begin
              w_addrNext   = BASE;
              w_dataNext   = CLEAR_WORD;
              w_clrCntNext = 16'd0;
              w_stateNext  = CLEAR;
            end
            default: begin
              w_addrNext  = w_cellAddr;
              w_dataNext  = {i_in_attr, i_in_char};
              w_stateNext = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        if (!i_ram_busy) begin
          w_stateNext = IDLE;
          if (r_col == LAST_COL) begin
            w_colNext = 8'd0;
            w_rowNext = w_rowInc;
          end else begin
            w_colNext = r_col + 8'd1;
          end
        end
      end
      CLEAR: begin
        // Address and count only move on a cycle the write actually lands.
        if (!i_ram_busy) begin
          w_addrNext   = r_addr + 16'd1;
          w_clrCntNext = r_clrCnt + 16'd1;
          if (r_clrCnt == LAST_CELL) begin
            w_stateNext = IDLE;
            w_colNext   = 8'd0;
            w_rowNext   = 8'd0;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign o_in_ready        = (r_state == IDLE);
  assign o_ram_writeenable = (r_state != IDLE) && !i_ram_busy;
  assign o_ram_addr        = r_addr;
  assign o_ram_write       = r_data;
  assign o_cur_col         = r_col;
  assign o_cur_row         = r_row;

endmodule

// File: tb/tb_tile_text_writer.sv
// Directed bench for tile_text_writer: characters, cursor wrap, control codes,
// busy stalls, form-feed clear and reset during a clear.
module tb_tile_text_writer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_in_valid = 1'b0;
  logic [7:0]  i_in_char = 8'd0;
  logic [7:0]  i_in_attr = 8'd0;
  logic        i_ram_busy = 1'b0;
  logic        o_in_ready;
  logic [15:0] o_ram_addr, o_ram_write;
  logic        o_ram_writeenable;
  logic [7:0]  o_cur_col, o_cur_row;

  int testsRun = 0;
  int testsFailed = 0;
  int writeCount = 0;
  int busyViol = 0;
  int clrBad = 0;
  int clrStart = 0;
  bit clearMode = 1'b0;
  logic [15:0] lastAddr = 16'd0;
  logic [15:0] lastData = 16'd0;

  tile_text_writer dut (
    .i_clk(clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_char(i_in_char), .i_in_attr(i_in_attr), .i_ram_busy(i_ram_busy),
    .o_ram_addr(o_ram_addr), .o_ram_write(o_ram_write),
    .o_ram_writeenable(o_ram_writeenable), .o_cur_col(o_cur_col), .o_cur_row(o_cur_row)
  );

  always #5 clk = ~clk;

  // Logs each strobe half a cycle before the RAM commits it on the next rising edge.
  always @(negedge clk) begin
    if (o_ram_writeenable) begin
      writeCount <= writeCount + 1;
      lastAddr   <= o_ram_addr;
      lastData   <= o_ram_write;
      if (i_ram_busy) busyViol <= busyViol + 1;
      if (clearMode && (o_ram_addr != 16'(writeCount - clrStart) || o_ram_write != 16'h0020))
        clrBad <= clrBad + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!o_in_ready && n < 5000) begin
      tick();
      n++;
    end
    if (!o_in_ready) checkOutput("idleTimeout", 32'(o_in_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] ch, input logic [7:0] at);
    waitIdle();
    i_in_valid = 1'b1;
    i_in_char  = ch;
    i_in_attr  = at;
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    int snap;
    int weSeen;
    int unstable;
    int n;

    doReset();
    checkOutput("rstReady", 32'(o_in_ready), 32'd1);
    checkOutput("rstCol", 32'(o_cur_col), 32'd0);
    checkOutput("rstRow", 32'(o_cur_row), 32'd0);
    checkOutput("rstAddr", 32'(o_ram_addr), 32'h0000);
    checkOutput("rstData", 32'(o_ram_write), 32'h0000);
    checkOutput("rstWe", 32'(o_ram_writeenable), 32'd0);

    // Single character and its latency
    snap = writeCount;
    applyStimulus(8'h41, 8'h07);
    checkOutput("aReadyLow", 32'(o_in_ready), 32'd0);
    checkOutput("aAddr", 32'(o_ram_addr), 32'h0000);
    checkOutput("aData", 32'(o_ram_write), 32'h0741);
    checkOutput("aWe", 32'(o_ram_writeenable), 32'd1);
    tick();
    checkOutput("aReadyBack", 32'(o_in_ready), 32'd1);
    checkOutput("aCol", 32'(o_cur_col), 32'd1);
    tick();
    checkOutput("aOneWrite", 32'(writeCount - snap), 32'd1);
    checkOutput("aLastData", 32'(lastData), 32'h0741);

    // Column wrap at the end of row 0
    doReset();
    snap = writeCount;
    for (int i = 0; i < 31; i++) applyStimulus(8'h61, 8'h02);
    waitIdle();
    checkOutput("fillCol", 32'(o_cur_col), 32'd31);
    checkOutput("fillWrites", 32'(writeCount - snap), 32'd31);
    applyStimulus(8'h5A, 8'h1E);
    checkOutput("zAddr", 32'(o_ram_addr), 32'h001F);
    checkOutput("zData", 32'(o_ram_write), 32'h1E5A);
    waitIdle();
    checkOutput("zCol", 32'(o_cur_col), 32'd0);
    checkOutput("zRow", 32'(o_cur_row), 32'd1);

    // Row wrap on LF, BS and CR behaviour
    for (int i = 0; i < 28; i++) applyStimulus(8'h0A, 8'h00);
    checkOutput("lfRow29", 32'(o_cur_row), 32'd29);
    for (int i = 0; i < 5; i++) applyStimulus(8'h63, 8'h00);
    waitIdle();
    checkOutput("preLfCol", 32'(o_cur_col), 32'd5);
    snap = writeCount;
    applyStimulus(8'h0A, 8'h00);
    checkOutput("lfReady", 32'(o_in_ready), 32'd1);
    checkOutput("lfWrapCol", 32'(o_cur_col), 32'd0);
    checkOutput("lfWrapRow", 32'(o_cur_row), 32'd0);
    applyStimulus(8'h08, 8'h00);
    checkOutput("bsCol0", 32'(o_cur_col), 32'd0);
    tick();
    checkOutput("ctrlNoWrite", 32'(writeCount - snap), 32'd0);
    applyStimulus(8'h62, 8'h00);
    applyStimulus(8'h63, 8'h00);
    waitIdle();
    applyStimulus(8'h08, 8'h00);
    checkOutput("bsCol", 32'(o_cur_col), 32'd1);
    applyStimulus(8'h0D, 8'h00);
    checkOutput("crCol", 32'(o_cur_col), 32'd0);
    applyStimulus(8'h0A, 8'h00);
    checkOutput("lfRow1", 32'(o_cur_row), 32'd1);

    // Write stalled by ram_busy
    i_ram_busy = 1'b1;
    snap = writeCount;
    applyStimulus(8'h51, 8'h42);
    weSeen = 0;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_ram_writeenable) weSeen++;
      if (o_ram_addr != 16'h0020 || o_ram_write != 16'h4251) unstable++;
      tick();
    end
    checkOutput("busyWe", 32'(weSeen), 32'd0);
    checkOutput("busyStable", 32'(unstable), 32'd0);
    checkOutput("busyNoWrite", 32'(writeCount - snap), 32'd0);
    i_ram_busy = 1'b0;
    tick();
    tick();
    checkOutput("busyOneWrite", 32'(writeCount - snap), 32'd1);
    checkOutput("busyLastAddr", 32'(lastAddr), 32'h0020);
    checkOutput("busyLastData", 32'(lastData), 32'h4251);
    checkOutput("busyCol", 32'(o_cur_col), 32'd1);
    checkOutput("busyRow", 32'(o_cur_row), 32'd1);

    // Form-feed clear with ram_busy toggling every cycle
    waitIdle();
    clrStart = writeCount;
    clearMode = 1'b1;
    applyStimulus(8'h0C, 8'h00);
    n = 0;
    while (!o_in_ready && n < 5000) begin
      i_ram_busy = ~i_ram_busy;
      tick();
      n++;
    end
    i_ram_busy = 1'b0;
    checkOutput("clrDone", 32'(o_in_ready), 32'd1);
    tick();
    checkOutput("clrWrites", 32'(writeCount - clrStart), 32'd960);
    checkOutput("clrOrder", 32'(clrBad), 32'd0);
    checkOutput("clrLastAddr", 32'(lastAddr), 32'h03BF);
    checkOutput("clrCol", 32'(o_cur_col), 32'd0);
    checkOutput("clrRow", 32'(o_cur_row), 32'd0);
    checkOutput("busyViolations", 32'(busyViol), 32'd0);

    // Reset in the middle of a clear
    clearMode = 1'b0;
    applyStimulus(8'h6B, 8'h00);
    waitIdle();
    tick();
    clrStart = writeCount;
    clearMode = 1'b1;
    applyStimulus(8'h0C, 8'h00);
    n = 0;
    while ((writeCount - clrStart) < 99 && n < 500) begin
      tick();
      n++;
    end
    i_reset = 1'b1;
    tick();
    checkOutput("abortWe", 32'(o_ram_writeenable), 32'd0);
    snap = writeCount;
    i_reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checkOutput("abortNoWrites", 32'(writeCount - snap), 32'd0);
    checkOutput("abortCount", 32'(writeCount - clrStart), 32'd100);
    checkOutput("abortOrder", 32'(clrBad), 32'd0);
    checkOutput("abortAddr", 32'(o_ram_addr), 32'h0000);
    checkOutput("abortData", 32'(o_ram_write), 32'h0000);
    checkOutput("abortReady", 32'(o_in_ready), 32'd1);
    checkOutput("abortCol", 32'(o_cur_col), 32'd0);
    checkOutput("abortRow", 32'(o_cur_row), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
